rv_decode_issue: RTL and testbench

- Instruction decode and issue front-end for the register-file/ALU datapath.
- Accepts 32-bit RV32I instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes one instruction per cycle into the datapath's control fields: rs1, rs2, ws, op, imm_e, imm_d.
- Flags unsupported encodings and counts legal issues.

---
 rtl/rv_decode_issue_pkg.sv | 8 +
 rtl/rv_decode_issue_instr_fifo.sv | 36 +++
 rtl/rv_decode_issue.sv | 87 ++++++++
 tb/tb_rv_decode_issue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_issue_pkg.sv
// rv_decode_issue_pkg: ALU control codes and the RV32I opcode/funct encodings the front-end accepts
package rv_decode_issue_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111, ALU_SGE = 4'b1000, ALU_NOR = 4'b1100;
  localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000, F3_AND = 3'b111, F3_OR = 3'b110, F3_SLT = 3'b010;
  localparam logic [6:0] F7_ZERO = 7'b0000000, F7_SUB = 7'b0100000;
endpackage

// File: rtl/rv_decode_issue_instr_fifo.sv
// instr_fifo: power-of-two instruction buffer; callers never push when full or pop when empty
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= wdata;
endmodule

// File: rtl/rv_decode_issue.sv
// rv_decode_issue: buffers RV32I words and issues one decoded ALU instruction per cycle
module rv_decode_issue
  import rv_decode_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic                  stall,
  input  logic                  flush,
  output logic [NAME_BITS-1:0]  rs1,
  output logic [NAME_BITS-1:0]  rs2,
  output logic [NAME_BITS-1:0]  ws,
  output logic [CTRL_BITS-1:0]  op,
  output logic                  imm_e,
  output logic [DATA_WIDTH-1:0] imm_d,
  output logic                  issue_valid,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  issue_count
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic                  legal;
    logic [NAME_BITS-1:0]  rs1;
    logic [NAME_BITS-1:0]  rs2;
    logic [NAME_BITS-1:0]  ws;
    logic [CTRL_BITS-1:0]  op;
    logic                  imm_e;
    logic [DATA_WIDTH-1:0] imm_d;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic alu;
    logic [3:0] aop;
    f3 = i[14:12];
    f7 = i[31:25];
    alu = f3 inside {F3_ADD, F3_AND, F3_OR, F3_SLT};
    aop = f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_SLT ? ALU_SLT : ALU_ADD;
    d = '0;
    d.rs1 = NAME_BITS'(i[19:15]);
    d.ws = NAME_BITS'(i[11:7]);
    if (i[6:0] == OP_REG) begin
      d.legal = (alu && f7 == F7_ZERO) || (f3 == F3_ADD && f7 == F7_SUB);
      d.op = CTRL_BITS'(f7 == F7_SUB ? ALU_SUB : aop);
      d.rs2 = NAME_BITS'(i[24:20]);
    end else if (i[6:0] == OP_IMM) begin
      // the top immediate bits may not look like a SUB funct7: there is no SUBI
      d.legal = alu && f7 != F7_SUB;
      d.op = CTRL_BITS'(aop);
      d.imm_e = 1'b1;
      d.imm_d = DATA_WIDTH'($signed(i[31:20]));
    end
    return d;
  endfunction
  logic [31:0] head;
  logic [CW-1:0] count;
  logic push, pop;
  dec_t dec, q;
  assign in_ready = rst & (count != CW'(DEPTH));
  assign push = in_valid & in_ready;
  assign pop = ~stall & ~flush & (count != '0);
  assign dec = decode(head);
  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wdata(in_instr), .rdata(head), .count(count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q <= '0;
      illegal <= 1'b0;
      issue_count <= '0;
    end else begin
      q <= pop && dec.legal ? dec : '0;
      illegal <= pop & ~dec.legal;
      issue_count <= issue_count + CNT_WIDTH'(pop & dec.legal);
    end
  assign {issue_valid, rs1, rs2, ws, op, imm_e, imm_d} = q;
endmodule

// File: tb/tb_rv_decode_issue.sv
// tb_rv_decode_issue: directed test-plan cases plus random traffic against a queue-based reference
module tb_rv_decode_issue;
  localparam int DEPTH = 4;
  localparam logic [6:0] REG = 7'b0110011, IMM = 7'b0010011;
  localparam logic [2:0] RF3 [5] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd2};
  localparam logic [6:0] RF7 [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
  localparam logic [3:0] ROP [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7};
  localparam logic [2:0] BF3 [4] = '{3'd1, 3'd3, 3'd4, 3'd5};
  typedef struct {
    logic [31:0] w;
    logic        lg;
    logic [3:0]  op;
    logic        ie;
    logic [31:0] imm;
    logic [4:0]  r1, r2, wd;
  } ent_t;
  logic clk = 0, rst = 0, in_valid = 0, stall = 0, flush = 0;
  logic [31:0] in_instr = '0;
  logic in_ready, imm_e, issue_valid, illegal;
  logic [4:0] rs1, rs2, ws;
  logic [3:0] op;
  logic [31:0] imm_d;
  logic [15:0] issue_count;
  int checks = 0, errors = 0;
  ent_t q[$];
  logic ex_v, ex_ill, ex_ie;
  logic [4:0] ex_r1, ex_r2, ex_wd;
  logic [3:0] ex_op;
  logic [31:0] ex_imm;
  logic [15:0] ex_cnt = '0, cnt0;
  logic acc;
  ent_t nil, five [5];
  rv_decode_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2), .ws(ws), .op(op), .imm_e(imm_e),
    .imm_d(imm_d), .issue_valid(issue_valid), .illegal(illegal), .issue_count(issue_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ent_t mk(logic [31:0] w, logic lg, logic [3:0] o, logic ie, logic [31:0] imm,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] wd);
    ent_t e;
    e.w = w; e.lg = lg; e.op = o; e.ie = ie; e.imm = imm; e.r1 = r1; e.r2 = r2; e.wd = wd;
    return e;
  endfunction
  function automatic ent_t addi(logic [4:0] rd, logic [11:0] im);
    return mk({im, 5'd0, 3'd0, rd, IMM}, 1, 4'd2, 1, {{20{im[11]}}, im}, 0, 0, rd);
  endfunction
  // builds a word from a known mnemonic so the expected fields come with it
  function automatic ent_t rnd_ent();
    ent_t e;
    int k, m, j;
    logic [4:0] a, b, d;
    logic [11:0] im;
    logic [6:0] x;
    a = 5'($urandom); b = 5'($urandom); d = 5'($urandom); im = 12'($urandom);
    k = $urandom_range(0, 9);
    j = $urandom_range(0, 4);
    e = mk(0, 0, 0, 0, 0, 0, 0, 0);
    if (k < 4) begin
      e = mk({RF7[j], b, a, RF3[j], d, REG}, 1, ROP[j], 0, 0, a, b, d);
    end else if (k < 7) begin
      m = $urandom_range(0, 3);
      if (m > 0) m++;
      if (im[11:5] == 7'h20) im[11] = 1'b1;
      e = mk({im, a, RF3[m], d, IMM}, 1, ROP[m], 1, {{20{im[11]}}, im}, a, 0, d);
    end else begin
      m = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: begin
          e.w = $urandom;
          x = 7'($urandom);
          if (x == REG || x == IMM) x = 7'b0110111;
          e.w[6:0] = x;
        end
        1: e.w = {7'h00, b, a, BF3[m], d, REG};
        2: begin
          x = 7'($urandom);
          if (x == 7'h00 || x == 7'h20) x = 7'h01;
          e.w = {x, b, a, RF3[j], d, REG};
        end
        3: e.w = {im, a, BF3[m], d, IMM};
        default: e.w = {7'h20, b, a, RF3[j], d, IMM};
      endcase
    end
    return e;
  endfunction
  task automatic nop_exp();
    ex_v = 0; ex_ill = 0; ex_ie = 0; ex_r1 = 0; ex_r2 = 0; ex_wd = 0; ex_op = 0; ex_imm = 0;
  endtask
  task automatic check_all();
    chk("in_ready", in_ready, rst && q.size() < DEPTH);
    chk("issue_valid", issue_valid, ex_v);
    chk("illegal", illegal, ex_ill);
    chk("rs1", rs1, ex_r1);
    chk("rs2", rs2, ex_r2);
    chk("ws", ws, ex_wd);
    chk("op", op, ex_op);
    chk("imm_e", imm_e, ex_ie);
    chk("imm_d", imm_d, ex_imm);
    chk("issue_count", issue_count, ex_cnt);
  endtask
  task automatic step(input logic v, input ent_t e, input logic st, input logic fl, output logic a);
    ent_t h;
    @(negedge clk);
    check_all();
    in_valid = v; in_instr = e.w; stall = st; flush = fl;
    a = v && q.size() < DEPTH;
    nop_exp();
    if (fl) q.delete();
    else begin
      if (!st && q.size() > 0) begin
        h = q.pop_front();
        if (h.lg) begin
          ex_v = 1; ex_r1 = h.r1; ex_r2 = h.r2; ex_wd = h.wd; ex_op = h.op; ex_ie = h.ie; ex_imm = h.imm;
          ex_cnt++;
        end else ex_ill = 1;
      end
      if (a) q.push_back(e);
    end
  endtask
  task automatic idle(input int n);
    logic a;
    repeat (n) step(0, nil, 0, 0, a);
  endtask
  initial begin
    nil = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) five[i] = addi(5'(i + 1), 12'(i * 3 + 1));
    nop_exp();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1;
    step(1, mk(32'h00500093, 1, 4'b0010, 1, 32'd5, 0, 0, 1), 0, 0, acc);
    idle(2);
    chk("addi_count", issue_count, 1);
    step(1, mk(32'hFFB00213, 1, 4'b0010, 1, 32'hFFFFFFFB, 0, 0, 4), 0, 0, acc);
    step(1, mk(32'h40300233, 1, 4'b0110, 0, 0, 0, 3, 4), 0, 0, acc);
    step(1, mk(32'h0020C1B3, 0, 0, 0, 0, 0, 0, 0), 0, 0, acc);
    idle(3);
    chk("xor_count", issue_count, 3);
    cnt0 = ex_cnt;
    for (int n = 0, t = 0; n < 4 && t < 20; t++) begin
      step(1, five[n], 1, 0, acc);
      if (acc) n++;
    end
    @(posedge clk);
    #1 chk("full_ready", in_ready, 0);
    step(1, five[4], 1, 0, acc);
    step(1, five[4], 1, 0, acc);
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) step(1, five[4], 0, 0, acc);
    idle(8);
    chk("stall_count", issue_count, cnt0 + 16'd5);
    for (int n = 0; n < 3; n++) step(1, five[n], 1, 0, acc);
    step(1, five[3], 0, 1, acc);
    idle(3);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 7, rnd_ent(), $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0, acc);
    idle(6);
    for (int n = 0; n < 3; n++) step(1, five[n], 1, 0, acc);
    step(0, nil, 0, 0, acc);
    @(negedge clk);
    check_all();
    rst = 0; in_valid = 0;
    #1;
    q.delete();
    nop_exp();
    ex_cnt = '0;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1;
    idle(3);
    @(negedge clk);
    check_all();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
